// File: rtl/noc_sched_pkg.sv
// Shared types for the router switch/VC scheduler.
// Port directions, flit kinds and credit width.
package noc_sched_pkg;

  localparam int PN  = 5;
  localparam int VCN = 2;
  localparam int CRD = 4;
  localparam int CW  = $clog2(CRD + 1);

  typedef enum logic [2:0] {
    DIR_S = 3'd0,
    DIR_W = 3'd1,
    DIR_N = 3'd2,
    DIR_E = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  // {hd, tl} as seen on the request side
  typedef enum logic [1:0] {
    FL_BOF = 2'b00,
    FL_EOF = 2'b01,
    FL_HOF = 2'b10,
    FL_SOF = 2'b11
  } flit_e;

  typedef logic [CW-1:0] credit_t;

endpackage

// File: rtl/vc_sw_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant, pointer moves
// past the winner when adv is high and something won.
module rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] ptr_q;
  logic [W-1:0] win;
  logic [W-1:0] idx;
  logic         hit;

  always_comb begin
    gnt = '0;
    win = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr_q) + i) % N);
      if (!hit && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv && hit) begin
      ptr_q <= (win == W'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/vc_sw_sched.sv
// Wormhole VC ownership + per-port switch allocation
// with downstream credit tracking and crossbar selects.
module vc_sw_sched
  import noc_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PN*VCN-1:0]     req,
  input  logic [PN*VCN*PN-1:0]  req_dir,
  input  logic [PN*VCN-1:0]     req_hd,
  input  logic [PN*VCN-1:0]     req_tl,
  input  logic [PN*VCN-1:0]     cr_in,
  output logic [PN*VCN-1:0]     gnt,
  output logic [PN*PN-1:0]      xb_ip,
  output logic [PN*VCN-1:0]     xb_vc,
  output logic                  err
);

  localparam int NV  = PN * VCN;
  localparam int PIW = $clog2(PN);

  logic [NV-1:0]    own_v_q;
  logic [PIW-1:0]   own_p_q [NV];
  credit_t          cr_q    [NV];

  logic [NV-1:0]    dir_ok;
  logic [NV*PN-1:0] oa_req;
  logic [NV*PN-1:0] oa_gnt;
  logic [NV-1:0]    oa_adv;
  logic [NV-1:0]    own_req;
  logic [NV-1:0]    sa_req;
  logic [NV-1:0]    sa_gnt;
  logic [PIW-1:0]   sel_p   [NV];
  logic [NV-1:0]    g_hd;
  logic [NV-1:0]    g_tl;
  logic             bad_dir;
  logic             bad_body;
  logic             ovf;

  always_comb begin
    bad_dir = 1'b0;
    for (int i = 0; i < NV; i++) begin
      dir_ok[i] = $onehot(req_dir[i*PN +: PN]);
      if (req[i] && !dir_ok[i]) bad_dir = 1'b1;
    end
  end

  // index ov = o*VCN+v is the output VC; p*VCN+v the input VC
  always_comb begin
    oa_req   = '0;
    own_req  = '0;
    bad_body = 1'b0;
    for (int o = 0; o < PN; o++) begin
      for (int v = 0; v < VCN; v++) begin
        for (int p = 0; p < PN; p++) begin
          if (req[p*VCN+v] && dir_ok[p*VCN+v] &&
              req_dir[(p*VCN+v)*PN+o]) begin
            if (req_hd[p*VCN+v]) begin
              if (!own_v_q[o*VCN+v])
                oa_req[(o*VCN+v)*PN+p] = 1'b1;
            end else if (own_v_q[o*VCN+v] &&
                         own_p_q[o*VCN+v] == PIW'(p)) begin
              own_req[o*VCN+v] = 1'b1;
            end else begin
              bad_body = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NV; i++) begin
      sel_p[i] = own_p_q[i];
      if (!own_v_q[i]) begin
        for (int p = 0; p < PN; p++)
          if (oa_gnt[i*PN+p]) sel_p[i] = PIW'(p);
      end
      sa_req[i] = (own_req[i] ||
                   (!own_v_q[i] && |oa_gnt[i*PN +: PN])) &&
                  (cr_q[i] != '0);
    end
  end

  always_comb begin
    gnt   = '0;
    xb_ip = '0;
    xb_vc = '0;
    g_hd  = '0;
    g_tl  = '0;
    for (int o = 0; o < PN; o++) begin
      for (int v = 0; v < VCN; v++) begin
        if (rst_n && sa_gnt[o*VCN+v]) begin
          xb_vc[o*VCN+v] = 1'b1;
          for (int p = 0; p < PN; p++) begin
            if (sel_p[o*VCN+v] == PIW'(p)) begin
              xb_ip[o*PN+p]   = 1'b1;
              gnt[p*VCN+v]    = 1'b1;
              g_hd[o*VCN+v]   = req_hd[p*VCN+v];
              g_tl[o*VCN+v]   = req_tl[p*VCN+v];
            end
          end
        end
      end
    end
  end

  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < NV; i++)
      if (cr_in[i] && !sa_gnt[i] && cr_q[i] == credit_t'(CRD))
        ovf = 1'b1;
  end

  assign oa_adv = sa_gnt & ~own_v_q;

  for (genvar i = 0; i < NV; i++) begin : g_oa
    rr_arb #(.N(PN)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (oa_req[i*PN +: PN]),
      .adv   (oa_adv[i]),
      .gnt   (oa_gnt[i*PN +: PN])
    );
  end

  for (genvar o = 0; o < PN; o++) begin : g_sa
    rr_arb #(.N(VCN)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (sa_req[o*VCN +: VCN]),
      .adv   (1'b1),
      .gnt   (sa_gnt[o*VCN +: VCN])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_v_q <= '0;
      err     <= 1'b0;
      for (int i = 0; i < NV; i++) begin
        own_p_q[i] <= '0;
        cr_q[i]    <= credit_t'(CRD);
      end
    end else begin
      for (int i = 0; i < NV; i++) begin
        // hd&tl leaves the owner free
        if (sa_gnt[i]) begin
          if (g_tl[i]) begin
            own_v_q[i] <= 1'b0;
          end else if (g_hd[i]) begin
            own_v_q[i] <= 1'b1;
            own_p_q[i] <= sel_p[i];
          end
        end
        if (sa_gnt[i] && !cr_in[i])
          cr_q[i] <= cr_q[i] - 1'b1;
        else if (!sa_gnt[i] && cr_in[i] &&
                 cr_q[i] != credit_t'(CRD))
          cr_q[i] <= cr_q[i] + 1'b1;
      end
      if (bad_dir || bad_body || ovf) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_sw_sched.sv
// Scoreboard bench for vc_sw_sched: directed flit
// sequences with hand-derived grant/crossbar values.
module tb_vc_sw_sched;

  typedef struct packed {
    logic [9:0]  g;
    logic [24:0] ip;
    logic [9:0]  vc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  req;
  logic [49:0] req_dir;
  logic [9:0]  req_hd;
  logic [9:0]  req_tl;
  logic [9:0]  cr_in;
  logic [9:0]  gnt;
  logic [24:0] xb_ip;
  logic [9:0]  xb_vc;
  logic        err;

  exp_t q[$];
  exp_t m_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vc_sw_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_dir (req_dir),
    .req_hd  (req_hd),
    .req_tl  (req_tl),
    .cr_in   (cr_in),
    .gnt     (gnt),
    .xb_ip   (xb_ip),
    .xb_vc   (xb_vc),
    .err     (err)
  );

  always @(negedge clk) begin
    if (gnt != '0 || xb_ip != '0 || xb_vc != '0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_grant gnt=%h ip=%h vc=%h",
                 gnt, xb_ip, xb_vc);
      end else begin
        m_e = q.pop_front();
        if ({gnt, xb_ip, xb_vc} !== m_e) begin
          bad++;
          $display("FAIL sb got gnt=%h ip=%h vc=%h want gnt=%h ip=%h vc=%h",
                   gnt, xb_ip, xb_vc, m_e.g, m_e.ip, m_e.vc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input int v, input int d,
                     input logic hd, input logic tl);
    int iv;
    iv = p * 2 + v;
    req[iv]            = 1'b1;
    req_dir[iv*5 +: 5] = 5'b00001 << d;
    req_hd[iv]         = hd;
    req_tl[iv]         = tl;
  endtask

  task automatic drop(input int p, input int v);
    int iv;
    iv = p * 2 + v;
    req[iv]            = 1'b0;
    req_dir[iv*5 +: 5] = '0;
    req_hd[iv]         = 1'b0;
    req_tl[iv]         = 1'b0;
  endtask

  task automatic push(input logic [9:0] g, input logic [24:0] ip,
                      input logic [9:0] vc);
    q.push_back('{g: g, ip: ip, vc: vc});
  endtask

  task automatic stall(input string nm);
    @(negedge clk);
    chk(nm, {22'd0, gnt}, 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    req_dir = '0;
    req_hd  = '0;
    req_tl  = '0;
    cr_in   = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_gnt", {22'd0, gnt}, 32'd0);
      chk("idle_ip", {7'd0, xb_ip}, 32'd0);
      chk("idle_err", {31'd0, err}, 32'd0);
      tick();
    end

    // local(4) vc0 -> north, 3 flits
    put(4, 0, 2, 1'b1, 1'b0);
    push(10'h100, 25'h0004000, 10'h010);
    tick();
    put(4, 0, 2, 1'b0, 1'b0);
    push(10'h100, 25'h0004000, 10'h010);
    tick();
    put(4, 0, 2, 1'b0, 1'b1);
    push(10'h100, 25'h0004000, 10'h010);
    tick();
    drop(4, 0);
    // lock released: new head from east gets the VC
    put(3, 0, 2, 1'b1, 1'b1);
    push(10'h040, 25'h0002000, 10'h010);
    tick();
    drop(3, 0);
    cr_in[4] = 1'b1;
    repeat (4) tick();
    cr_in[4] = 1'b0;

    // two heads to east vc1: p0 wins, p1 waits
    cr_in[7] = 1'b1;
    put(0, 1, 3, 1'b1, 1'b0);
    put(1, 1, 3, 1'b1, 1'b0);
    push(10'h002, 25'h0008000, 10'h080);
    tick();
    put(0, 1, 3, 1'b0, 1'b0);
    push(10'h002, 25'h0008000, 10'h080);
    tick();
    put(0, 1, 3, 1'b0, 1'b1);
    push(10'h002, 25'h0008000, 10'h080);
    tick();
    drop(0, 1);
    chk("wait_head_err", {31'd0, err}, 32'd0);
    push(10'h008, 25'h0010000, 10'h080);
    tick();
    put(1, 1, 3, 1'b0, 1'b1);
    push(10'h008, 25'h0010000, 10'h080);
    tick();
    drop(1, 1);
    // pointer now past p1: p2 beats p0
    put(0, 1, 3, 1'b1, 1'b1);
    put(2, 1, 3, 1'b1, 1'b1);
    push(10'h020, 25'h0020000, 10'h080);
    tick();
    drop(2, 1);
    push(10'h002, 25'h0008000, 10'h080);
    tick();
    drop(0, 1);
    cr_in[7] = 1'b0;

    // two VCs on north alternate
    put(0, 0, 2, 1'b1, 1'b0);
    put(1, 1, 2, 1'b1, 1'b0);
    push(10'h008, 25'h0000800, 10'h020);
    tick();
    put(1, 1, 2, 1'b0, 1'b1);
    push(10'h001, 25'h0000400, 10'h010);
    tick();
    put(0, 0, 2, 1'b0, 1'b1);
    push(10'h008, 25'h0000800, 10'h020);
    tick();
    drop(1, 1);
    push(10'h001, 25'h0000400, 10'h010);
    tick();
    drop(0, 0);

    // 5-flit packet north(2) vc0 -> west, 4 credits
    put(2, 0, 1, 1'b1, 1'b0);
    push(10'h010, 25'h0000080, 10'h004);
    tick();
    put(2, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(10'h010, 25'h0000080, 10'h004);
      tick();
    end
    put(2, 0, 1, 1'b0, 1'b1);
    cr_in[2] = 1'b1;
    stall("no_credit");
    tick();
    push(10'h010, 25'h0000080, 10'h004);
    tick();
    cr_in[2] = 1'b0;
    // grant+credit same edge kept the count at 1
    put(2, 0, 1, 1'b1, 1'b1);
    push(10'h010, 25'h0000080, 10'h004);
    tick();
    stall("credit_used");
    tick();
    drop(2, 0);
    cr_in[2] = 1'b1;
    repeat (4) tick();
    cr_in[2] = 1'b0;

    // single-flit packets to south vc0
    chk("pre_ovf_err", {31'd0, err}, 32'd0);
    put(1, 0, 0, 1'b1, 1'b1);
    push(10'h004, 25'h0000002, 10'h001);
    tick();
    drop(1, 0);
    put(3, 0, 0, 1'b1, 1'b1);
    push(10'h040, 25'h0000008, 10'h001);
    tick();
    drop(3, 0);
    cr_in[0] = 1'b1;
    tick();
    tick();
    cr_in[0] = 1'b0;
    @(negedge clk);
    chk("full_err", {31'd0, err}, 32'd0);
    cr_in[0] = 1'b1;
    tick();
    cr_in[0] = 1'b0;
    @(negedge clk);
    chk("ovf_err", {31'd0, err}, 32'd1);
    tick();
    put(1, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push(10'h004, 25'h0000002, 10'h001);
      tick();
    end
    stall("sat_credit");
    tick();
    drop(1, 0);

    // reset mid-packet on local vc0
    put(0, 0, 4, 1'b1, 1'b0);
    push(10'h001, 25'h0100000, 10'h100);
    tick();
    put(0, 0, 4, 1'b0, 1'b0);
    push(10'h001, 25'h0100000, 10'h100);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", {22'd0, gnt}, 32'd0);
    chk("rst_ip", {7'd0, xb_ip}, 32'd0);
    chk("rst_vc", {22'd0, xb_vc}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    drop(0, 0);
    tick();
    rst_n = 1'b1;
    put(1, 0, 4, 1'b1, 1'b0);
    push(10'h004, 25'h0200000, 10'h100);
    tick();
    put(1, 0, 4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(10'h004, 25'h0200000, 10'h100);
      tick();
    end
    stall("rst_credit4");
    tick();
    drop(1, 0);

    // body flit without ownership
    put(3, 0, 0, 1'b0, 1'b0);
    stall("body_no_owner");
    tick();
    drop(3, 0);
    @(negedge clk);
    chk("body_err", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // two-hot direction
    req[5]         = 1'b1;
    req_dir[25+:5] = 5'b00110;
    req_hd[5]      = 1'b1;
    req_tl[5]      = 1'b1;
    @(negedge clk);
    chk("dir_err_pre", {31'd0, err}, 32'd0);
    chk("dir_gnt", {22'd0, gnt}, 32'd0);
    tick();
    drop(2, 1);
    @(negedge clk);
    chk("dir_err", {31'd0, err}, 32'd1);

    tick();
    tick();
    chk("sb_drain", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
